// File: rtl/binario_a_bcd.sv
// Sequential binary-to-BCD converter (shift-add-3) for the DPWM display path.
// One bit per clock; digits are registered and change only together with the done pulse.
module binario_a_bcd #(
   parameter int unsigned WIDTH = 12
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic [WIDTH-1:0] binario,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [3:0]       unidades,
   output logic [3:0]       decenas,
   output logic [3:0]       centenas,
   output logic [3:0]       millares
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } state_e;

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] w_bin_next;
   logic [15:0]      r_scratch;
   logic [15:0]      w_scratch_next;
   logic [15:0]      w_corr;
   logic [15:0]      w_shifted;
   logic [15:0]      r_digits;
   logic [15:0]      w_digits_next;
   logic [CntW-1:0]  r_count;
   logic [CntW-1:0]  w_count_next;
   logic             r_done;
   logic             w_done_next;
   logic             w_last;

   // Nibbles are corrected independently; a corrected nibble (<=12) never carries out.
   always_comb begin
      w_corr = '0;
      for (int n = 0; n < 4; n++) begin
         if (r_scratch[4*n +: 4] >= 4'd5) begin
            w_corr[4*n +: 4] = r_scratch[4*n +: 4] + 4'd3;
         end else begin
            w_corr[4*n +: 4] = r_scratch[4*n +: 4];
         end
      end
   end

   assign w_shifted = {w_corr[14:0], r_bin[WIDTH-1]};
   assign w_last    = (r_count == CntW'(1));

   always_comb begin
      w_state_next   = r_state;
      w_bin_next     = r_bin;
      w_scratch_next = r_scratch;
      w_count_next   = r_count;
      w_digits_next  = r_digits;
      w_done_next    = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_bin_next     = binario;
               w_scratch_next = '0;
               w_count_next   = CntW'(WIDTH);
               w_state_next   = StShift;
            end
         end
         StShift: begin
            w_scratch_next = w_shifted;
            w_bin_next     = r_bin << 1;
            w_count_next   = r_count - CntW'(1);
            if (w_last) begin
               w_digits_next = w_shifted;
               w_done_next   = 1'b1;
               w_state_next  = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state   <= StIdle;
         r_bin     <= '0;
         r_scratch <= '0;
         r_count   <= '0;
         r_digits  <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_bin     <= w_bin_next;
         r_scratch <= w_scratch_next;
         r_count   <= w_count_next;
         r_digits  <= w_digits_next;
         r_done    <= w_done_next;
      end
   end

   assign busy     = (r_state == StShift);
   assign done     = r_done;
   assign unidades = r_digits[3:0];
   assign decenas  = r_digits[7:4];
   assign centenas = r_digits[11:8];
   assign millares = r_digits[15:12];

endmodule

// File: tb/tb_binario_a_bcd.sv
// Randomized bench for binario_a_bcd: WIDTH=12 and WIDTH=13 instances checked against
// a decimal-arithmetic reference.
module tb_binario_a_bcd;

   logic        CLK;
   logic        reset;
   logic [11:0] bin12;
   logic        start12;
   logic        busy12;
   logic        done12;
   logic [3:0]  u12, d12, c12, m12;
   logic [12:0] bin13;
   logic        start13;
   logic        busy13;
   logic        done13;
   logic [3:0]  u13, d13, c13, m13;
   logic [15:0] dig12;
   logic [15:0] dig13;

   int checks = 0;
   int errors = 0;

   binario_a_bcd #(.WIDTH(12)) u_dut12 (
      .CLK      (CLK),
      .reset    (reset),
      .binario  (bin12),
      .start    (start12),
      .busy     (busy12),
      .done     (done12),
      .unidades (u12),
      .decenas  (d12),
      .centenas (c12),
      .millares (m12)
   );

   binario_a_bcd #(.WIDTH(13)) u_dut13 (
      .CLK      (CLK),
      .reset    (reset),
      .binario  (bin13),
      .start    (start13),
      .busy     (busy13),
      .done     (done13),
      .unidades (u13),
      .decenas  (d13),
      .centenas (c13),
      .millares (m13)
   );

   assign dig12 = {m12, c12, d12, u12};
   assign dig13 = {m13, c13, d13, u13};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [15:0] ref_bcd(input int unsigned v);
      ref_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Returns cycles from accepting edge until done seen (bounded) and busy cycles observed.
   task automatic wait_done12(output int cycles, output int busy_cycles);
      cycles = 0;
      busy_cycles = 0;
      while (!done12 && cycles < 40) begin
         if (busy12) busy_cycles++;
         tick();
         cycles++;
      end
   endtask

   task automatic wait_done13(output int cycles);
      cycles = 0;
      while (!done13 && cycles < 40) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++;
      if ({busy12, done12, dig12} !== 18'd0) begin
         errors++;
         $display("FAIL reset12: got busy=%b done=%b dig=%h, want 0 0 0000", busy12, done12, dig12);
      end
      checks++;
      if ({busy13, done13, dig13} !== 18'd0) begin
         errors++;
         $display("FAIL reset13: got busy=%b done=%b dig=%h, want 0 0 0000", busy13, done13, dig13);
      end
   endtask

   task automatic test_zero();
      int cyc, bcyc;
      bin12 = 12'd0;
      start12 = 1'b1;
      tick();
      start12 = 1'b0;
      wait_done12(cyc, bcyc);
      checks++;
      if (cyc != 12 || dig12 !== 16'h0000) begin
         errors++;
         $display("FAIL zero: got latency=%0d dig=%h, want 12 0000", cyc, dig12);
      end
      tick();
   endtask

   task automatic test_max();
      int cyc, bcyc;
      bin12 = 12'd4095;
      start12 = 1'b1;
      tick();
      start12 = 1'b0;
      wait_done12(cyc, bcyc);
      checks++;
      if (cyc != 12 || dig12 !== 16'h4095) begin
         errors++;
         $display("FAIL max12: got latency=%0d dig=%h, want 12 4095", cyc, dig12);
      end
      checks++;
      if (bcyc != 12) begin
         errors++;
         $display("FAIL busy_len: got %0d busy cycles, want 12", bcyc);
      end
      tick();
      checks++;
      if (done12 !== 1'b0 || busy12 !== 1'b0) begin
         errors++;
         $display("FAIL done_width: got done=%b busy=%b after pulse, want 0 0", done12, busy12);
      end
   endtask

   task automatic test_ignore_start();
      int k, hold_bad, extra;
      bin12 = 12'd1234;
      start12 = 1'b1;
      tick();
      start12 = 1'b0;
      k = 1;
      hold_bad = 0;
      while (k <= 40 && !done12) begin
         if (dig12 !== 16'h4095) hold_bad++;
         start12 = (k == 3 || k == 7);
         bin12 = 12'd999;
         tick();
         k++;
      end
      start12 = 1'b0;
      checks++;
      if (k - 1 != 12 || dig12 !== 16'h1234) begin
         errors++;
         $display("FAIL ignore: got latency=%0d dig=%h, want 12 1234", k - 1, dig12);
      end
      checks++;
      if (hold_bad != 0) begin
         errors++;
         $display("FAIL hold: got %0d cycles with changed digits during busy, want 0", hold_bad);
      end
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done12 || busy12) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL no_queue: got %0d busy/done cycles after result, want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      int c1, c2, b;
      logic [15:0] first;
      bin12 = 12'd9;
      start12 = 1'b1;
      tick();
      bin12 = 12'd10;
      wait_done12(c1, b);
      first = dig12;
      tick();
      start12 = 1'b0;
      wait_done12(c2, b);
      checks++;
      if (c1 != 12 || first !== 16'h0009) begin
         errors++;
         $display("FAIL b2b_first: got latency=%0d dig=%h, want 12 0009", c1, first);
      end
      checks++;
      if (c2 + 1 != 13 || dig12 !== 16'h0010) begin
         errors++;
         $display("FAIL b2b_second: got spacing=%0d dig=%h, want 13 0010", c2 + 1, dig12);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int extra;
      bin12 = 12'd555;
      start12 = 1'b1;
      tick();
      start12 = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (busy12 !== 1'b0 || done12 !== 1'b0 || dig12 !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b done=%b dig=%h, want 0 0 0000",
                  busy12, done12, dig12);
      end
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done12) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL reset_abort: got %0d done pulses after reset, want 0", extra);
      end
   endtask

   task automatic test_random12();
      int cyc, bcyc;
      int unsigned v;
      for (int n = 0; n < 40; n++) begin
         v = $urandom_range(0, 4095);
         bin12 = 12'(v);
         start12 = 1'b1;
         tick();
         start12 = 1'b0;
         bin12 = 12'($urandom);
         wait_done12(cyc, bcyc);
         checks++;
         if (cyc != 12 || dig12 !== ref_bcd(v)) begin
            errors++;
            $display("FAIL rand12 v=%0d: got latency=%0d dig=%h, want 12 %h",
                     v, cyc, dig12, ref_bcd(v));
         end
      end
   endtask

   task automatic test_w13();
      int cyc;
      int unsigned v;
      v = 0;
      while (v <= 8191) begin
         bin13 = 13'(v);
         start13 = 1'b1;
         tick();
         start13 = 1'b0;
         wait_done13(cyc);
         checks++;
         if (cyc != 13 || dig13 !== ref_bcd(v)) begin
            errors++;
            $display("FAIL w13 v=%0d: got latency=%0d dig=%h, want 13 %h",
                     v, cyc, dig13, ref_bcd(v));
         end
         if (v == 8191) break;
         v = v + $urandom_range(1, 24);
         if (v > 8191) v = 8191;
      end
   endtask

   initial begin
      reset = 1'b0;
      bin12 = '0;
      start12 = 1'b0;
      bin13 = '0;
      start13 = 1'b0;
      test_reset();
      test_zero();
      test_max();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_random12();
      test_w13();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
